regfile_sb: RTL

- Parametrised successor to the fixed 32x32 register file.
- Generic width and depth, two combinational read ports and one write port.
- Optional hard-wired zero register and optional write-to-read bypass.
- Per-register busy scoreboard (reserve at issue, clear at writeback) with a registered busy-count. It sits between the decode/issue and writeback stages of the pipelined core.

---
 rtl/regfile_sb.sv | 109 ++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy scoreboard.
//   Two combinational read ports, one write port, optional hard-wired zero
//   register, optional same-cycle write-to-read bypass. A reserve marks a
//   register busy (pending producer) at issue; the write clears it at
//   writeback. busy_count is the registered number of busy registers.
// Ports:
//   clock, ctrl_reset                  rising-edge clock, async active-high reset
//   ctrl_writeEnable/WriteReg, data_writeReg   write port
//   ctrl_readRegA/B -> data_readRegA/B          combinational read data
//   ctrl_reserveEnable/ctrl_reserveReg          scoreboard reserve
//   busy_readRegA/B                             combinational busy of read index
//   busy_count                                  registered busy population
module regfile_sb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_reserveEnable,
  input  logic [ADDR_W-1:0] ctrl_reserveReg,
  output logic              busy_readRegA,
  output logic              busy_readRegB,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_c, rsv_en_c, inc_c, dec_c;
  logic             zero_a_c, zero_b_c, byp_a_c, byp_b_c;

  // Writes/reserves to the hard-wired zero register are dropped here.
  assign wr_en_c  = ctrl_writeEnable   && !(ZERO_REG && (ctrl_writeReg   == '0));
  assign rsv_en_c = ctrl_reserveEnable && !(ZERO_REG && (ctrl_reserveReg == '0));

  // Scoreboard next state: the write clears, then the reserve sets, so a
  // same-index pair leaves the bit set (reserve is the newer producer).
  always_comb begin
    busy_d = busy_q;
    if (wr_en_c)  busy_d[ctrl_writeReg]   = 1'b0;
    if (rsv_en_c) busy_d[ctrl_reserveReg] = 1'b1;
  end

  // Incremental count: only real 0->1 and 1->0 transitions move it.
  always_comb begin
    inc_c   = rsv_en_c && !busy_q[ctrl_reserveReg];
    dec_c   = wr_en_c && busy_q[ctrl_writeReg] &&
              !(rsv_en_c && (ctrl_reserveReg == ctrl_writeReg));
    count_d = count_q + CNT_W'(inc_c) - CNT_W'(dec_c);
  end

  // Storage, scoreboard and count registers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_c) regs_q[ctrl_writeReg] <= data_writeReg;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read port A.
  always_comb begin
    zero_a_c      = ZERO_REG && (ctrl_readRegA == '0);
    byp_a_c       = BYPASS && wr_en_c && (ctrl_writeReg == ctrl_readRegA);
    data_readRegA = regs_q[ctrl_readRegA];
    busy_readRegA = busy_q[ctrl_readRegA];
    if (zero_a_c) begin
      data_readRegA = '0;
      busy_readRegA = 1'b0;
    end else if (byp_a_c) begin
      data_readRegA = data_writeReg;
      busy_readRegA = rsv_en_c && (ctrl_reserveReg == ctrl_readRegA);
    end
  end

  // Read port B.
  always_comb begin
    zero_b_c      = ZERO_REG && (ctrl_readRegB == '0);
    byp_b_c       = BYPASS && wr_en_c && (ctrl_writeReg == ctrl_readRegB);
    data_readRegB = regs_q[ctrl_readRegB];
    busy_readRegB = busy_q[ctrl_readRegB];
    if (zero_b_c) begin
      data_readRegB = '0;
      busy_readRegB = 1'b0;
    end else if (byp_b_c) begin
      data_readRegB = data_writeReg;
      busy_readRegB = rsv_en_c && (ctrl_reserveReg == ctrl_readRegB);
    end
  end

  assign busy_count = count_q;

endmodule
